// File: rtl/pixel_sensor_ctrl.sv
// Frame sequencer for the pixel array: ERASE -> EXPOSE -> ramp CONVERT -> one-hot row readout.
// Latency: start sampled at a posedge, erase rises on the following cycle; all outputs registered.
// Backpressure: row_ready gates each row transfer; read/row_valid hold indefinitely while it is low.
//
// Ports:
//   clk, reset (sync, active-low), start, abort, expose_time  -- control inputs
//   erase, expose, convert, counter                            -- pixel/ramp phase controls
//   read, row_index, row_valid, row_ready                      -- row readout handshake
//   busy, frame_done                                           -- status
// Optional build macro PIXEL_CTRL_CONTINUOUS_EN adds input 'continuous': after the last row the
// sequencer loops through GAP into the next ERASE instead of returning to IDLE.

module pixel_sensor_ctrl #(
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int COUNTER_BITS       = 8,
  parameter int ERASE_CYCLES       = 5,
  parameter int READ_ROW_CYCLES    = 5,
  localparam int ROW_BITS = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
`ifdef PIXEL_CTRL_CONTINUOUS_EN
  input  logic                          continuous,
`endif
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [COUNTER_BITS-1:0]       expose_time,
  output logic                          erase,
  output logic                          expose,
  output logic                          convert,
  output logic [COUNTER_BITS-1:0]       counter,
  output logic [PIXEL_ARRAY_HEIGHT-1:0] read,
  output logic [ROW_BITS-1:0]           row_index,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic                          busy,
  output logic                          frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_GAP, S_EXPOSE, S_CONVERT, S_READ_SETTLE, S_READ_WAIT
  } state_t;

  localparam logic [31:0] ERASE_LAST   = 32'(ERASE_CYCLES - 1);
  localparam logic [31:0] CONVERT_LAST = 32'((2 ** COUNTER_BITS) - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(READ_ROW_CYCLES - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(PIXEL_ARRAY_HEIGHT - 1);

  state_t                    state, state_n;
  state_t                    gap_ret, gap_ret_n;   // phase that follows the current GAP
  logic [31:0]               timer, timer_n;       // cycles spent in the current phase
  logic [COUNTER_BITS-1:0]   exp_lat, exp_n;
  logic [ROW_BITS-1:0]       row, row_n;
  logic                      done_n;
  logic                      rd_n;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_n;
  logic [COUNTER_BITS-1:0]   exp_in;

  // A zero exposure would skip the phase entirely; clamp to one cycle.
  assign exp_in = (expose_time == '0) ? COUNTER_BITS'(1) : expose_time;

  always_comb begin
    state_n   = state;
    gap_ret_n = gap_ret;
    timer_n   = timer + 32'd1;
    exp_n     = exp_lat;
    row_n     = row;
    done_n    = 1'b0;

    case (state)
      S_IDLE: begin
        timer_n = '0;
        row_n   = '0;
        if (start) begin
          state_n = S_ERASE;
          exp_n   = exp_in;
        end
      end
      S_ERASE: begin
        if (timer == ERASE_LAST) begin
          state_n   = S_GAP;
          gap_ret_n = S_EXPOSE;
          timer_n   = '0;
        end
      end
      S_GAP: begin
        state_n = gap_ret;
        timer_n = '0;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
        if (gap_ret == S_ERASE) exp_n = exp_in;
`endif
      end
      S_EXPOSE: begin
        if ((timer + 32'd1) == 32'(exp_lat)) begin
          state_n   = S_GAP;
          gap_ret_n = S_CONVERT;
          timer_n   = '0;
        end
      end
      S_CONVERT: begin
        if (timer == CONVERT_LAST) begin
          state_n   = S_GAP;
          gap_ret_n = S_READ_SETTLE;
          timer_n   = '0;
          row_n     = '0;
        end
      end
      S_READ_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_n = S_READ_WAIT;
          timer_n = '0;
        end
      end
      S_READ_WAIT: begin
        timer_n = '0;
        // row_valid is high throughout this state, so row_ready alone marks the transfer.
        if (row_ready) begin
          if (row == LAST_ROW) begin
            done_n  = 1'b1;
            row_n   = '0;
            state_n = S_IDLE;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
            if (continuous) begin
              state_n   = S_GAP;
              gap_ret_n = S_ERASE;
            end
`endif
          end else begin
            row_n   = row + ROW_BITS'(1);
            state_n = S_READ_SETTLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      timer_n = '0;
      row_n   = '0;
      done_n  = 1'b0;
    end
  end

  assign rd_n   = (state_n == S_READ_SETTLE) || (state_n == S_READ_WAIT);
  assign read_n = PIXEL_ARRAY_HEIGHT'(1) << row_n;

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      gap_ret    <= S_IDLE;
      timer      <= '0;
      exp_lat    <= '0;
      row        <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      counter    <= '0;
      read       <= '0;
      row_index  <= '0;
      row_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      gap_ret    <= gap_ret_n;
      timer      <= timer_n;
      exp_lat    <= exp_n;
      row        <= row_n;
      erase      <= (state_n == S_ERASE);
      expose     <= (state_n == S_EXPOSE);
      convert    <= (state_n == S_CONVERT);
      counter    <= (state_n == S_CONVERT) ? timer_n[COUNTER_BITS-1:0] : '0;
      read       <= rd_n ? read_n : '0;
      row_index  <= rd_n ? row_n : '0;
      row_valid  <= (state_n == S_READ_WAIT);
      busy       <= (state_n != S_IDLE);
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Directed testbench for pixel_sensor_ctrl with default parameters (4 rows, 8-bit ramp).
// Each task drives one scenario and checks observed outputs against hand-computed values.
// Outputs are sampled 1 ns after the rising edge; inputs change at the same point.

module tb_pixel_sensor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expose_time = 8'd10;
  logic       erase, expose, convert;
  logic [7:0] counter;
  logic [3:0] read;
  logic [1:0] row_index;
  logic       row_valid;
  logic       row_ready = 1'b1;
  logic       busy, frame_done;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
  logic       continuous = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  // Statistics gathered by run_frame (stimulus only, no checks inside).
  int first_erase_k, erase_cnt, first_expose_k, expose_cnt, first_convert_k, convert_cnt;
  int counter_err, read_err, done_k, done_cnt, busy_drop, xfer_k, second_erase_k;
  int row_cnt [4];

  pixel_sensor_ctrl dut (
`ifdef PIXEL_CTRL_CONTINUOUS_EN
    .continuous (continuous),
`endif
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .expose_time(expose_time),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .counter    (counter),
    .read       (read),
    .row_index  (row_index),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller raises start before calling; k counts cycles after the start cycle.
  task automatic run_frame(input int budget, input int n_done, input bit poke_start);
    bit poked = 1'b0;
    bit prev_erase = 1'b0;
    int erase_rises = 0;
    int conv_val = 0;
    first_erase_k = -1; erase_cnt = 0; first_expose_k = -1; expose_cnt = 0;
    first_convert_k = -1; convert_cnt = 0; counter_err = 0; read_err = 0;
    done_k = -1; done_cnt = 0; busy_drop = 0; xfer_k = -1; second_erase_k = -1;
    for (int r = 0; r < 4; r++) row_cnt[r] = 0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      start = 1'b0;
      if (poke_start && expose && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (erase) begin
        erase_cnt++;
        if (first_erase_k < 0) first_erase_k = k;
        if (!prev_erase) begin
          erase_rises++;
          if (erase_rises == 2) second_erase_k = k;
        end
      end
      prev_erase = erase;
      if (expose) begin
        expose_cnt++;
        if (first_expose_k < 0) first_expose_k = k;
      end
      if (convert) begin
        if (first_convert_k < 0) first_convert_k = k;
        if (int'(counter) != (conv_val & 255)) counter_err++;
        conv_val++;
        convert_cnt++;
      end else if (counter != 8'd0) counter_err++;
      if (read != 4'd0) begin
        if (read != (4'd1 << row_index)) read_err++;
        row_cnt[row_index]++;
      end else if (row_index != 2'd0 || row_valid) read_err++;
      if (row_valid && row_ready && row_index == 2'd3 && xfer_k < 0) xfer_k = k;
      if (frame_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (!busy && done_cnt < n_done) busy_drop++;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
      if (done_cnt >= 1) continuous = 1'b0;
`endif
      if (done_cnt >= n_done && k >= done_k + 2) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    total++;
    if ({erase, expose, convert, counter, read, row_index, row_valid, busy, frame_done} !== 21'd0)
      $display("FAIL reset_init: outputs=%h required 0",
               {erase, expose, convert, counter, read, row_index, row_valid, busy, frame_done});
    else passed++;
    reset = 1'b1;
    expose_time = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (convert && counter == 8'd50) break;
      tick();
    end
    total++;
    if (!(convert && counter == 8'd50)) $display("FAIL reset_reach_convert: convert=%b counter=%0d required 1/50", convert, counter);
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({erase, expose, convert, counter, read, row_index, row_valid, busy, frame_done} !== 21'd0)
        $display("FAIL reset_midframe_%0d: outputs=%h required 0", i,
                 {erase, expose, convert, counter, read, row_index, row_valid, busy, frame_done});
      else passed++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    expose_time = 8'd10;
    row_ready = 1'b1;
    start = 1'b1;
    run_frame(400, 1, 1'b0);
    total++; if (first_erase_k !== 1)   $display("FAIL frame_erase_start: got %0d required 1", first_erase_k); else passed++;
    total++; if (erase_cnt !== 5)       $display("FAIL frame_erase_len: got %0d required 5", erase_cnt); else passed++;
    total++; if (first_expose_k !== 7)  $display("FAIL frame_expose_start: got %0d required 7", first_expose_k); else passed++;
    total++; if (expose_cnt !== 10)     $display("FAIL frame_expose_len: got %0d required 10", expose_cnt); else passed++;
    total++; if (first_convert_k !== 18) $display("FAIL frame_convert_start: got %0d required 18", first_convert_k); else passed++;
    total++; if (convert_cnt !== 256)   $display("FAIL frame_convert_len: got %0d required 256", convert_cnt); else passed++;
    total++; if (counter_err !== 0)     $display("FAIL frame_counter_ramp: %0d bad cycles required 0", counter_err); else passed++;
    total++; if (read_err !== 0)        $display("FAIL frame_read_onehot: %0d bad cycles required 0", read_err); else passed++;
    for (int r = 0; r < 4; r++) begin
      total++;
      if (row_cnt[r] !== 6) $display("FAIL frame_row%0d_len: got %0d required 6", r, row_cnt[r]);
      else passed++;
    end
    total++; if (done_k !== 299)  $display("FAIL frame_done_cycle: got %0d required 299", done_k); else passed++;
    total++; if (done_cnt !== 1)  $display("FAIL frame_done_count: got %0d required 1", done_cnt); else passed++;
    total++; if (busy !== 1'b0)   $display("FAIL frame_idle_busy: got %b required 0", busy); else passed++;
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    bit held_ok = 1'b1;
    expose_time = 8'd1;
    row_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (row_index == 2'd2 && read == 4'b0100) begin seen = 1'b1; break; end
      tick();
    end
    row_ready = 1'b0;
    for (int i = 0; i < 10 && !row_valid; i++) tick();
    total++;
    if (!(seen && row_valid)) $display("FAIL bp_reach_row2: seen=%b row_valid=%b required 1/1", seen, row_valid);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      if (read !== 4'b0100 || row_valid !== 1'b1 || row_index !== 2'd2) held_ok = 1'b0;
      if (i < 19) tick();
    end
    total++;
    if (!held_ok) $display("FAIL bp_hold: read=%b row_valid=%b required 0100/1", read, row_valid);
    else passed++;
    row_ready = 1'b1;
    tick();
    total++;
    if (row_index !== 2'd3 || read !== 4'b1000 || row_valid !== 1'b0)
      $display("FAIL bp_next_row: row_index=%0d read=%b row_valid=%b required 3/1000/0", row_index, read, row_valid);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_done) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) $display("FAIL bp_frame_done: seen=0 required 1");
    else passed++;
    tick(); tick();
  endtask

  task automatic test_expose_zero();
    expose_time = 8'd0;
    start = 1'b1;
    run_frame(400, 1, 1'b1);
    total++; if (expose_cnt !== 1)  $display("FAIL ez_expose_len: got %0d required 1", expose_cnt); else passed++;
    total++; if (erase_cnt !== 5)   $display("FAIL ez_no_restart: erase cycles %0d required 5", erase_cnt); else passed++;
    total++; if (done_k !== 290)    $display("FAIL ez_done_cycle: got %0d required 290", done_k); else passed++;
  endtask

  task automatic test_abort();
    bit stray_done = 1'b0;
    expose_time = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (convert && counter == 8'd100) break;
      tick();
    end
    total++;
    if (!(convert && counter == 8'd100)) $display("FAIL abort_reach: counter=%0d required 100", counter);
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (convert !== 1'b0 || counter !== 8'd0 || busy !== 1'b0 || read !== 4'd0)
      $display("FAIL abort_idle: convert=%b counter=%0d busy=%b read=%b required 0/0/0/0", convert, counter, busy, read);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (frame_done || busy) stray_done = 1'b1;
      tick();
    end
    total++;
    if (stray_done) $display("FAIL abort_no_done: frame_done/busy seen=1 required 0");
    else passed++;
    start = 1'b1;
    run_frame(400, 1, 1'b0);
    total++; if (done_k !== 299) $display("FAIL abort_restart_done: got %0d required 299", done_k); else passed++;
  endtask

`ifdef PIXEL_CTRL_CONTINUOUS_EN
  task automatic test_continuous();
    expose_time = 8'd10;
    continuous = 1'b1;
    start = 1'b1;
    run_frame(800, 2, 1'b0);
    total++; if (done_cnt !== 2)   $display("FAIL cont_done_count: got %0d required 2", done_cnt); else passed++;
    total++; if (busy_drop !== 0)  $display("FAIL cont_busy_drop: got %0d required 0", busy_drop); else passed++;
    total++;
    if (second_erase_k - xfer_k !== 2) $display("FAIL cont_erase_gap: got %0d required 2", second_erase_k - xfer_k);
    else passed++;
    total++; if (erase_cnt !== 10) $display("FAIL cont_erase_len: got %0d required 10", erase_cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_expose_zero();
    test_abort();
`ifdef PIXEL_CTRL_CONTINUOUS_EN
    test_continuous();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_sensor_ctrl.md
Name: pixel_sensor_ctrl

Overview:
Synthesizable frame sequencer for the pixel array. Drives ERASE, EXPOSE and the ramp-convert phase, including the digital ramp counter, and performs one-hot row readout with a valid/ready handshake toward downstream capture logic. It replaces bench-side sequencing and sits between the system top and the pixel array plus its ADC ramp.

Parameters:
PIXEL_ARRAY_HEIGHT, 4, number of rows; width of read.
COUNTER_BITS, 8, digital ramp width; CONVERT lasts 2^COUNTER_BITS cycles.
ERASE_CYCLES, 5, cycles erase is held high.
READ_ROW_CYCLES, 5, settle cycles per row before row_valid.

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 resets)
start  input  1  begin one frame; sampled only in IDLE
abort  input  1  synchronous abort to IDLE
expose_time  input  COUNTER_BITS  exposure length in cycles, latched at start
erase  output  1  pixel erase
expose  output  1  pixel expose
convert  output  1  ramp enable; gates the analog ramp
counter  output  COUNTER_BITS  digital ramp value to the pixel array
read  output  PIXEL_ARRAY_HEIGHT  one-hot row select
row_index  output  $clog2(PIXEL_ARRAY_HEIGHT)  row currently selected
row_valid  output  1  selected row data settled
row_ready  input  1  downstream accepts the row
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse after the last row transfers

Behaviour:
- States: IDLE, ERASE, GAP, EXPOSE, CONVERT, READ_SETTLE, READ_WAIT. All outputs are registered.
- Reset (reset==0 at posedge): state IDLE. All outputs 0, including read, counter and row_index. Reset applies from any state, mid-frame included.
- IDLE: all controls 0, busy=0.
  - start=1 at a posedge: latch expose_time (0 is treated as 1). ERASE begins next cycle.
  - start is ignored while busy.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles.
- GAP: one cycle with all controls 0 (break-before-make). Inserted after ERASE, after EXPOSE and after CONVERT only.
- EXPOSE: expose=1 for exactly the latched expose_time cycles.
- CONVERT:
  - convert=1 for 2^COUNTER_BITS cycles.
  - counter=0 on the first CONVERT cycle, +1 each cycle, all-ones on the last.
  - counter is 0 in every other state; it never wraps within the phase.
- READ_SETTLE:
  - read=1<<row_index, row_valid=0, for READ_ROW_CYCLES cycles.
  - row_index=0 on entry from GAP.
  - Then READ_WAIT.
- READ_WAIT: read held, row_valid=1 until the cycle where row_valid&&row_ready.
  - Transfer on row < HEIGHT-1: next cycle row_index+1, read shifts left, READ_SETTLE restarts. No gap between rows.
  - Transfer on the last row: next cycle IDLE, read=0, frame_done=1 for one cycle.
- row_ready while row_valid=0 has no effect. Backpressure is unbounded; read and row_valid stay stable.
- abort=1 in any non-IDLE state: next cycle IDLE, all outputs 0, no frame_done.
  - Reset has priority over abort; abort has priority over start.
- Frame latency with row_ready tied 1 and expose_time=E:
  - first erase cycle = start cycle + 1;
  - frame_done cycle = start cycle + 1 + ERASE_CYCLES + 1 + E + 1 + 2^COUNTER_BITS + 1 + HEIGHT*(READ_ROW_CYCLES+1).

Optional Feature:
PIXEL_CTRL_CONTINUOUS_EN:
- Defined:
  - Adds input port continuous (1 bit).
  - On the last-row transfer with continuous=1: frame_done still pulses, the FSM goes through GAP to ERASE, and expose_time is re-latched in that GAP cycle. busy stays 1.
  - abort still returns to IDLE.
- Undefined: the port is absent and the FSM always returns to IDLE after the last row.

Test Plan:
- Reset held (reset=0) 3 cycles from a mid-CONVERT state -> all outputs 0, busy=0, counter=0 on the first posedge with reset low.
- start 1-cycle pulse, expose_time=10, row_ready=1, defaults -> erase high 5 cycles, expose high 10, convert 256 cycles with counter 0..255, read 0001/0010/0100/1000 each 6 cycles, frame_done exactly 1 + 5+1+10+1+256+1+24 = 299 cycles after start.
- row_ready=0 for 20 cycles once row_index=2 is valid -> read=4'b0100 and row_valid=1 held for all 20 cycles; row 3 begins the cycle after ready rises.
- expose_time=0 -> expose high exactly 1 cycle; a start pulse during EXPOSE -> no effect.
- abort=1 when counter=100 in CONVERT -> next cycle IDLE, convert=0, counter=0, no frame_done; a new start then yields a normal frame.
- PIXEL_CTRL_CONTINUOUS_EN, continuous=1, 2 frames -> frame_done pulses twice, busy never drops, second erase starts 2 cycles after the first frame_done-producing transfer.
